// File: rtl/sram_sched_pkg.sv
// Shared types and constants for the SRAM pixel-write scheduler.
// Contents: screen bounds, pixel request payload, SRAM round phase encoding,
// and a saturating 8-bit adder used by the drop counter.
package sram_sched_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned COORD_W    = 10;
    localparam int unsigned PIX_DATA_W = 16;

    typedef struct packed {
        logic [COORD_W-1:0]    x;
        logic [COORD_W-1:0]    y;
        logic [PIX_DATA_W-1:0] data;
    } pixel_req_t;

    // Same encoding as the frame-buffer controller's round stage.
    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/sram_write_scheduler_sync_fifo.sv
// Synchronous FIFO with flush and occupancy.
// Ports: clk, reset (sync, active-high), push/wdata, pop/rdata (head, fall-through),
// flush (clears all entries, wins over push/pop), full, empty, level.
// A push while full is taken only when a pop happens on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q;
    logic [AW-1:0]    rd_q;
    logic [LW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == LW'(DEPTH));
    assign level   = cnt_q;
    assign rdata   = mem[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage array, no reset needed: contents are only read when counted valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush && !reset) begin
            mem[wr_q] <= wdata;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + LW'(1);
                2'b01:   cnt_q <= cnt_q - LW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/sram_write_scheduler.sv
// Round-robin pixel-write scheduler feeding the SRAM frame-buffer program port.
// Ports: sram_clk, reset (sync, active-high), frame_clk (frame swap level);
// req_valid/req_ready/req_x/req_y/req_data (packed per requester);
// program_x/program_y/program_data (to controller), frame_start (pulse after swap),
// fifo_level, drop_count (saturating), busy.
module sram_write_scheduler
    import sram_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter logic [9:0]  PARK_X     = 10'd1023,
    parameter logic [9:0]  PARK_Y     = 10'd511
) (
    input  logic                          sram_clk,
    input  logic                          reset,
    input  logic                          frame_clk,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*10-1:0]         req_x,
    input  logic [NUM_REQ*10-1:0]         req_y,
    input  logic [NUM_REQ*16-1:0]         req_data,
    output logic [9:0]                    program_x,
    output logic [9:0]                    program_y,
    output logic [15:0]                   program_data,
    output logic                          frame_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count,
    output logic                          busy
);

    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PIX_W  = $bits(pixel_req_t);
    localparam int          NREQ_I = int'(NUM_REQ);

    phase_e            phase_q;
    phase_e            phase_d;
    logic              update_c;

    logic              frame_clk_d;
    logic              rise_r;

    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  rr_d;
    logic [IDX_W-1:0]  grant_idx_c;
    logic              found_c;
    pixel_req_t        sel_c;
    logic              in_range_c;
    logic              accept_c;
    logic              push_c;
    logic              pop_c;

    logic [PIX_W-1:0]  fifo_rdata;
    pixel_req_t        head_c;
    logic              fifo_full;
    logic              fifo_empty;
    logic              out_valid_q;
    logic [7:0]        drop_d;

    // Phase state register; leaves reset together with the controller.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            phase_q <= PH_0;
        end else begin
            phase_q <= phase_d;
        end
    end

    // Phase sequencing; outputs move on the edges ending PH_0 and PH_2.
    always_comb begin
        phase_d  = PH_0;
        update_c = 1'b0;
        case (phase_q)
            PH_0: begin phase_d = PH_1; update_c = 1'b1; end
            PH_1: begin phase_d = PH_2; end
            PH_2: begin phase_d = PH_3; update_c = 1'b1; end
            PH_3: begin phase_d = PH_0; end
            default: begin phase_d = PH_0; end
        endcase
    end

    // Round-robin search starting at rr_q.
    always_comb begin
        found_c     = 1'b0;
        grant_idx_c = rr_q;
        for (int k = 0; k < NREQ_I; k++) begin
            if (!found_c && req_valid[(int'(rr_q) + k) % NREQ_I]) begin
                found_c     = 1'b1;
                grant_idx_c = IDX_W'((int'(rr_q) + k) % NREQ_I);
            end
        end
    end

    // Payload mux for the granted requester.
    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NREQ_I; i++) begin
            if (grant_idx_c == IDX_W'(i)) begin
                sel_c.x    = req_x[i*10 +: 10];
                sel_c.y    = req_y[i*10 +: 10];
                sel_c.data = req_data[i*16 +: 16];
            end
        end
    end

    // Flush beats pop; a full FIFO still accepts when its head leaves this edge.
    assign pop_c      = update_c && !fifo_empty && !rise_r;
    assign accept_c   = found_c && (!fifo_full || pop_c) && !rise_r && !reset;
    assign in_range_c = (sel_c.x < COORD_W'(SCREEN_W)) && (sel_c.y < COORD_W'(SCREEN_H));
    assign push_c     = accept_c && in_range_c;
    assign rr_d       = (grant_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_c + IDX_W'(1);
    assign head_c     = pixel_req_t'(fifo_rdata);

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NREQ_I; i++) begin
            req_ready[i] = accept_c && (grant_idx_c == IDX_W'(i));
        end
    end

    // Flushed entries and off-screen pixels both count as dropped.
    always_comb begin
        drop_d = drop_count;
        if (rise_r) begin
            drop_d = sat_add8(drop_count, 8'(fifo_level));
        end else if (accept_c && !in_range_c) begin
            drop_d = sat_add8(drop_count, 8'd1);
        end
    end

    sync_fifo #(
        .WIDTH (PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sram_clk),
        .reset (reset),
        .push  (push_c),
        .wdata (sel_c),
        .pop   (pop_c),
        .flush (rise_r),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Frame-swap edge detect matching the controller, plus output issue.
    always_ff @(posedge sram_clk) begin
        if (reset) begin
            frame_clk_d  <= 1'b0;
            rise_r       <= 1'b0;
            frame_start  <= 1'b0;
            rr_q         <= '0;
            drop_count   <= '0;
            program_x    <= PARK_X;
            program_y    <= PARK_Y;
            program_data <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            frame_clk_d <= frame_clk;
            rise_r      <= frame_clk & ~frame_clk_d;
            frame_start <= rise_r;
            drop_count  <= drop_d;
            if (accept_c) begin
                rr_q <= rr_d;
            end
            if (rise_r) begin
                program_x   <= PARK_X;
                program_y   <= PARK_Y;
                out_valid_q <= 1'b0;
            end else if (update_c) begin
                if (!fifo_empty) begin
                    program_x    <= head_c.x;
                    program_y    <= head_c.y;
                    program_data <= head_c.data;
                    out_valid_q  <= 1'b1;
                end else begin
                    program_x   <= PARK_X;
                    program_y   <= PARK_Y;
                    out_valid_q <= 1'b0;
                end
            end
        end
    end

    assign busy = out_valid_q || !fifo_empty;

endmodule

// File: tb/tb_sram_write_scheduler.sv
// Self-checking bench for sram_write_scheduler with a reference scoreboard monitor.
module tb_sram_write_scheduler;
    import sram_sched_pkg::*;

    localparam logic [9:0] PX = 10'd1023;
    localparam logic [9:0] PY = 10'd511;
    localparam int K_NONE = 0, K_PARK = 1, K_PIX = 2, K_RESET = 3;

    logic        sram_clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_clk = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [29:0] req_x = '0;
    logic [29:0] req_y = '0;
    logic [47:0] req_data = '0;
    logic [9:0]  program_x;
    logic [9:0]  program_y;
    logic [15:0] program_data;
    logic        frame_start;
    logic [4:0]  fifo_level;
    logic [7:0]  drop_count;
    logic        busy;

    int checks = 0;
    int passed = 0;

    // Reference model state
    pixel_req_t q[$];
    int         grant_log[$];
    int         issue_cyc[$];
    pixel_req_t issue_px[$];
    int         m_phase = 0;
    bit         m_fd = 0, m_rise = 0, m_fs = 0, m_outv = 0;
    int         m_drop = 0;
    int         cyc = 0;

    sram_write_scheduler dut (
        .sram_clk     (sram_clk),
        .reset        (reset),
        .frame_clk    (frame_clk),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_data     (req_data),
        .program_x    (program_x),
        .program_y    (program_y),
        .program_data (program_data),
        .frame_start  (frame_start),
        .fifo_level   (fifo_level),
        .drop_count   (drop_count),
        .busy         (busy)
    );

    always #5 sram_clk = ~sram_clk;

    function automatic int sat8(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    // Scoreboard monitor: predicts every edge, then compares just after it.
    always @(posedge sram_clk) begin : monitor
        int         acc, nacc, kind;
        logic [2:0] rdy_s;
        pixel_req_t apx, exp_px;
        logic [35:0] prev;
        nacc = 0;
        acc  = -1;
        rdy_s = req_ready;
        for (int i = 0; i < 3; i++) begin
            if (req_valid[i] && req_ready[i]) begin nacc++; acc = i; end
        end
        if (reset) begin
            checks++;
            if (rdy_s !== 3'b000) $display("FAIL ready_in_reset got=%b want=000", rdy_s);
            else passed++;
            q.delete();
            m_phase = 0; m_fd = 0; m_rise = 0; m_fs = 0; m_outv = 0; m_drop = 0;
            kind = K_RESET;
        end else begin
            checks++;
            if ($countones(rdy_s) > 1 || (m_rise && rdy_s != 3'b000))
                $display("FAIL ready_rule cyc=%0d got=%b rise=%0d", cyc, rdy_s, m_rise);
            else passed++;
            kind = K_NONE;
            if (m_rise) begin
                m_drop = sat8(m_drop + q.size());
                q.delete();
                kind = K_PARK;
            end else if (m_phase % 2 == 0) begin
                if (q.size() > 0) begin exp_px = q.pop_front(); kind = K_PIX; end
                else kind = K_PARK;
            end
            if (acc >= 0) begin
                apx.x = req_x[acc*10 +: 10];
                apx.y = req_y[acc*10 +: 10];
                apx.data = req_data[acc*16 +: 16];
                grant_log.push_back(acc);
                if (apx.x < 10'd640 && apx.y < 10'd480) q.push_back(apx);
                else m_drop = sat8(m_drop + 1);
            end
            m_fs = m_rise;
            m_rise = frame_clk & ~m_fd;
            m_fd = frame_clk;
            m_phase = (m_phase + 1) % 4;
            if (kind == K_PIX) m_outv = 1;
            else if (kind == K_PARK) m_outv = 0;
        end
        cyc++;
        #1;
        checks++;
        case (kind)
            K_RESET: if ({program_x, program_y, program_data} !== {PX, PY, 16'h0})
                         $display("FAIL reset_out cyc=%0d got x=%0d y=%0d d=%h want x=1023 y=511 d=0000", cyc, program_x, program_y, program_data);
                     else passed++;
            K_PARK:  if ({program_x, program_y} !== {PX, PY})
                         $display("FAIL park_out cyc=%0d got x=%0d y=%0d want x=1023 y=511", cyc, program_x, program_y);
                     else passed++;
            K_PIX:   if ({program_x, program_y, program_data} !== {exp_px.x, exp_px.y, exp_px.data})
                         $display("FAIL pix_out cyc=%0d got x=%0d y=%0d d=%h want x=%0d y=%0d d=%h", cyc, program_x, program_y, program_data, exp_px.x, exp_px.y, exp_px.data);
                     else passed++;
            default: if ({program_x, program_y, program_data} !== prev)
                         $display("FAIL hold_out cyc=%0d got %h want %h", cyc, {program_x, program_y, program_data}, prev);
                     else passed++;
        endcase
        if (kind == K_PIX) begin
            issue_cyc.push_back(cyc);
            issue_px.push_back(pixel_req_t'({program_x, program_y, program_data}));
        end
        prev = {program_x, program_y, program_data};
        checks++;
        if (fifo_level !== 5'(q.size())) $display("FAIL level cyc=%0d got=%0d want=%0d", cyc, fifo_level, q.size());
        else passed++;
        checks++;
        if (drop_count !== 8'(m_drop)) $display("FAIL drop cyc=%0d got=%0d want=%0d", cyc, drop_count, m_drop);
        else passed++;
        checks++;
        if (frame_start !== m_fs) $display("FAIL frame_start cyc=%0d got=%b want=%b", cyc, frame_start, m_fs);
        else passed++;
        checks++;
        if (busy !== (m_outv || q.size() > 0)) $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, (m_outv || q.size() > 0));
        else passed++;
    end

    // Drive one pixel on requester i, starting at the current negedge; returns at a negedge.
    task automatic send_one(input int i, input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
        bit got;
        int c;
        req_x[i*10 +: 10]    = x;
        req_y[i*10 +: 10]    = y;
        req_data[i*16 +: 16] = d;
        req_valid[i] = 1'b1;
        got = 0;
        c = 0;
        while (!got && c < 200) begin
            #1;
            got = req_ready[i];
            @(negedge sram_clk);
            c++;
        end
        req_valid[i] = 1'b0;
        checks++;
        if (!got) $display("FAIL send_timeout req=%0d got=no_ready want=ready", i);
        else passed++;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (!busy && q.size() == 0) begin ok = 1; break; end
            @(negedge sram_clk);
        end
    endtask

    task automatic test_reset();
        req_valid = 3'b111;
        repeat (3) @(negedge sram_clk);
        #1;
        checks++;
        if (req_ready !== 3'b000) $display("FAIL rst_ready got=%b want=000", req_ready); else passed++;
        checks++;
        if ({program_x, program_y, program_data} !== {PX, PY, 16'h0})
            $display("FAIL rst_out got x=%0d y=%0d d=%h want 1023/511/0000", program_x, program_y, program_data);
        else passed++;
        checks++;
        if ({busy, frame_start, drop_count, fifo_level} !== 15'd0)
            $display("FAIL rst_status got busy=%b fs=%b drop=%0d lvl=%0d want zeros", busy, frame_start, drop_count, fifo_level);
        else passed++;
        req_valid = '0;
        @(negedge sram_clk);
        reset = 1'b0;
    endtask

    task automatic test_idle();
        for (int c = 0; c < 40; c++) begin
            @(negedge sram_clk);
            if (m_phase % 2 == 1) begin
                checks++;
                if ({program_x, program_y, busy} !== {PX, PY, 1'b0})
                    $display("FAIL idle_park got x=%0d y=%0d busy=%b want 1023/511/0", program_x, program_y, busy);
                else passed++;
            end
        end
    endtask

    task automatic test_burst();
        bit ok;
        issue_cyc.delete();
        issue_px.delete();
        @(negedge sram_clk);
        for (int k = 0; k < 4; k++) send_one(0, 10'(10 + k), 10'd5, 16'hF800);
        wait_idle(ok);
        checks++;
        if (!ok) $display("FAIL burst_drain got=busy want=idle"); else passed++;
        checks++;
        if (issue_px.size() != 4) $display("FAIL burst_count got=%0d want=4", issue_px.size());
        else passed++;
        for (int k = 0; k < 4 && k < issue_px.size(); k++) begin
            checks++;
            if ({issue_px[k].x, issue_px[k].y, issue_px[k].data} !== {10'(10 + k), 10'd5, 16'hF800})
                $display("FAIL burst_order k=%0d got x=%0d y=%0d d=%h want x=%0d y=5 d=f800", k, issue_px[k].x, issue_px[k].y, issue_px[k].data, 10 + k);
            else passed++;
            if (k > 0) begin
                checks++;
                if (issue_cyc[k] - issue_cyc[k-1] != 2)
                    $display("FAIL burst_spacing k=%0d got=%0d want=2", k, issue_cyc[k] - issue_cyc[k-1]);
                else passed++;
            end
        end
        checks++;
        if ({program_x, program_y} !== {PX, PY}) $display("FAIL burst_park got x=%0d y=%0d want 1023/511", program_x, program_y);
        else passed++;
    endtask

    task automatic test_range();
        bit ok;
        issue_px.delete();
        @(negedge sram_clk);
        send_one(1, 10'd700, 10'd10, 16'h1234);
        send_one(2, 10'd5, 10'd480, 16'h5678);
        send_one(0, 10'd639, 10'd479, 16'h07E0);
        wait_idle(ok);
        checks++;
        if (drop_count !== 8'd2) $display("FAIL range_drop got=%0d want=2", drop_count); else passed++;
        checks++;
        if (issue_px.size() != 1) $display("FAIL range_issued got=%0d want=1", issue_px.size());
        else passed++;
        if (issue_px.size() > 0) begin
            checks++;
            if ({issue_px[0].x, issue_px[0].y, issue_px[0].data} !== {10'd639, 10'd479, 16'h07E0})
                $display("FAIL range_edge got x=%0d y=%0d d=%h want 639/479/07e0", issue_px[0].x, issue_px[0].y, issue_px[0].data);
            else passed++;
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] rdy;
        int cnt[3];
        bit filled, seq_ok, ok;
        @(negedge sram_clk);
        for (int i = 0; i < 3; i++) begin
            req_x[i*10 +: 10]    = 10'(100 + i * 100);
            req_y[i*10 +: 10]    = 10'(50 + i);
            req_data[i*16 +: 16] = 16'(i + 1);
        end
        req_valid = 3'b111;
        filled = 0;
        for (int c = 0; c < 200 && !filled; c++) begin
            #1; rdy = req_ready;
            @(negedge sram_clk);
            for (int i = 0; i < 3; i++) if (rdy[i]) req_x[i*10 +: 10] = req_x[i*10 +: 10] + 10'd1;
            if (q.size() == 16) filled = 1;
        end
        checks++;
        if (fifo_level !== 5'd16) $display("FAIL rr_fill got=%0d want=16", fifo_level); else passed++;
        grant_log.delete();
        for (int c = 0; c < 60; c++) begin
            #1; rdy = req_ready;
            @(negedge sram_clk);
            for (int i = 0; i < 3; i++) if (rdy[i]) req_x[i*10 +: 10] = req_x[i*10 +: 10] + 10'd1;
        end
        req_valid = '0;
        checks++;
        if (grant_log.size() != 30) $display("FAIL rr_accepts got=%0d want=30", grant_log.size()); else passed++;
        cnt = '{0, 0, 0};
        seq_ok = 1;
        for (int k = 0; k < grant_log.size(); k++) begin
            cnt[grant_log[k]]++;
            if (k > 0 && grant_log[k] != (grant_log[k-1] + 1) % 3) seq_ok = 0;
        end
        checks++;
        if (!seq_ok) $display("FAIL rr_order got=non_cyclic want=cyclic"); else passed++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (cnt[i] != 10) $display("FAIL rr_share req=%0d got=%0d want=10", i, cnt[i]); else passed++;
        end
        wait_idle(ok);
        checks++;
        if (!ok) $display("FAIL rr_drain got=busy want=idle"); else passed++;
    endtask

    task automatic test_flush();
        logic rdy0;
        bit ok, hit;
        int exp_drop;
        @(negedge sram_clk);
        req_x[9:0] = 10'd200; req_y[9:0] = 10'd100; req_data[15:0] = 16'h0001;
        req_valid = 3'b001;
        for (int c = 0; c < 200 && q.size() < 12; c++) begin
            #1; rdy0 = req_ready[0];
            @(negedge sram_clk);
            if (rdy0) req_x[9:0] = req_x[9:0] + 10'd1;
        end
        req_valid = '0;
        hit = 0;
        for (int c = 0; c < 100; c++) begin
            if (q.size() == 9 && m_phase % 2 == 1) begin hit = 1; break; end
            @(negedge sram_clk);
        end
        checks++;
        if (!hit) $display("FAIL flush_setup got=%0d want=9", q.size()); else passed++;
        exp_drop = sat8(m_drop + 9);
        frame_clk = 1'b1;
        @(negedge sram_clk);
        checks++;
        if ({frame_start, fifo_level} !== {1'b0, 5'd9}) $display("FAIL flush_pre got fs=%b lvl=%0d want 0/9", frame_start, fifo_level);
        else passed++;
        @(negedge sram_clk);
        checks++;
        if ({fifo_level, frame_start, busy} !== {5'd0, 1'b1, 1'b0})
            $display("FAIL flush_edge got lvl=%0d fs=%b busy=%b want 0/1/0", fifo_level, frame_start, busy);
        else passed++;
        checks++;
        if (drop_count !== 8'(exp_drop)) $display("FAIL flush_drop got=%0d want=%0d", drop_count, exp_drop); else passed++;
        checks++;
        if ({program_x, program_y} !== {PX, PY}) $display("FAIL flush_park got x=%0d y=%0d want 1023/511", program_x, program_y);
        else passed++;
        @(negedge sram_clk);
        checks++;
        if (frame_start !== 1'b0) $display("FAIL flush_pulse got=%b want=0", frame_start); else passed++;
        frame_clk = 1'b0;
        issue_px.delete();
        send_one(0, 10'd20, 10'd30, 16'hABCD);
        wait_idle(ok);
        checks++;
        if (issue_px.size() != 1 || issue_px[issue_px.size()-1].x !== 10'd20)
            $display("FAIL flush_after got n=%0d want one pixel x=20", issue_px.size());
        else passed++;
    endtask

    task automatic test_drop_saturate();
        @(negedge sram_clk);
        req_x[29:20] = 10'd800; req_y[29:20] = 10'd1; req_data[47:32] = 16'hFFFF;
        req_valid = 3'b100;
        repeat (300) @(negedge sram_clk);
        req_valid = '0;
        @(negedge sram_clk);
        checks++;
        if (drop_count !== 8'hFF) $display("FAIL drop_sat got=%0d want=255", drop_count); else passed++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int rel;
        @(negedge sram_clk);
        req_x[9:0] = 10'd50; req_y[9:0] = 10'd60; req_data[15:0] = 16'h00FF;
        req_valid = 3'b001;
        for (int c = 0; c < 200 && q.size() < 8; c++) @(negedge sram_clk);
        reset = 1'b1;
        req_valid = '0;
        @(negedge sram_clk);
        checks++;
        if ({fifo_level, drop_count, busy, frame_start} !== 15'd0)
            $display("FAIL midrst_status got lvl=%0d drop=%0d busy=%b fs=%b want zeros", fifo_level, drop_count, busy, frame_start);
        else passed++;
        checks++;
        if ({program_x, program_y, program_data} !== {PX, PY, 16'h0})
            $display("FAIL midrst_out got x=%0d y=%0d d=%h want 1023/511/0000", program_x, program_y, program_data);
        else passed++;
        reset = 1'b0;
        rel = cyc;
        issue_cyc.delete();
        issue_px.delete();
        send_one(1, 10'd300, 10'd200, 16'h0F0F);
        wait_idle(ok);
        checks++;
        if (issue_cyc.size() != 1 || issue_cyc[0] - rel != 3)
            $display("FAIL midrst_phase got n=%0d dt=%0d want n=1 dt=3", issue_cyc.size(), (issue_cyc.size() > 0) ? issue_cyc[0] - rel : -1);
        else passed++;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_idle();
        test_burst();
        test_range();
        test_round_robin();
        test_flush();
        test_drop_saturate();
        test_reset_mid();
        repeat (4) @(negedge sram_clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
